// File: rtl/spatz_pkg.sv
// Shared Spatz vector register file types.
package spatz_pkg;

   localparam int unsigned VRegAddrWidth = 8;
   localparam int unsigned VRegDataWidth = 32;
   localparam int unsigned VRegBeWidth   = VRegDataWidth / 8;

   typedef logic [VRegAddrWidth-1:0] vreg_addr_t;
   typedef logic [VRegDataWidth-1:0] vreg_data_t;
   typedef logic [VRegBeWidth-1:0]   vreg_be_t;

endpackage : spatz_pkg

// File: rtl/spatz_vrf_warb.sv
// VRF write-port arbiter: round-robin between requesters, with bounded
// multi-beat locking so a burst owner cannot starve the others.
module spatz_vrf_warb
   import spatz_pkg::*;
#(
   parameter int unsigned NrReq   = 3,
   parameter int unsigned MaxLock = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  vreg_addr_t [NrReq-1:0] req_waddr_i,
   input  vreg_data_t [NrReq-1:0] req_wdata_i,
   input  vreg_be_t   [NrReq-1:0] req_wbe_i,
   input  logic       [NrReq-1:0] req_we_i,
   input  logic       [NrReq-1:0] req_lock_i,
   output logic       [NrReq-1:0] req_wvalid_o,
   output vreg_addr_t             vrf_waddr_o,
   output vreg_data_t             vrf_wdata_o,
   output vreg_be_t               vrf_wbe_o,
   output logic                   vrf_we_o,
   input  logic                   vrf_wvalid_i
);

   localparam int unsigned RrW   = (NrReq > 1) ? $clog2(NrReq) : 1;
   localparam int unsigned CntW  = $clog2(MaxLock) + 1;
   localparam bit          LockEn = (MaxLock > 1);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e          state_q, state_d;
   logic [RrW-1:0]  rr_q, rr_d;
   logic [RrW-1:0]  owner_q, owner_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [RrW-1:0]  win_idx;
   logic            win_found;
   logic            accept;

   // Successor index with wrap-around, used to rotate priority.
   function automatic logic [RrW-1:0] next_idx(input logic [RrW-1:0] idx);
      if (idx == RrW'(NrReq - 1)) begin
         return '0;
      end
      return idx + RrW'(1);
   endfunction

   // Winner selection: the owner while locked, else round-robin from rr_q.
   always_comb begin
      int unsigned idx;
      win_idx   = '0;
      win_found = 1'b0;
      idx       = 0;
      if (state_q == LOCKED) begin
         win_idx   = owner_q;
         win_found = req_we_i[owner_q];
      end else begin
         for (int unsigned i = 0; i < NrReq; i++) begin
            idx = (int'(rr_q) + i) % NrReq;
            if (!win_found && req_we_i[idx]) begin
               win_found = 1'b1;
               win_idx   = RrW'(idx);
            end
         end
      end
   end

   assign accept = win_found & vrf_wvalid_i;

   // Zero-latency write port mux; idle port drives zeros.
   always_comb begin
      vrf_we_o     = win_found;
      vrf_waddr_o  = '0;
      vrf_wdata_o  = '0;
      vrf_wbe_o    = '0;
      req_wvalid_o = '0;
      if (win_found) begin
         vrf_waddr_o = req_waddr_i[win_idx];
         vrf_wdata_o = req_wdata_i[win_idx];
         vrf_wbe_o   = req_wbe_i[win_idx];
      end
      if (accept) begin
         req_wvalid_o[win_idx] = 1'b1;
      end
   end

   // Lock/rotate decisions.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LockEn && req_lock_i[win_idx]) begin
                  state_d = LOCKED;
                  owner_d = win_idx;
                  cnt_d   = CntW'(1);
               end else begin
                  rr_d = next_idx(win_idx);
               end
            end
         end
         LOCKED: begin
            if (accept) begin
               cnt_d = cnt_q + CntW'(1);
               if (!req_lock_i[owner_q] || (cnt_q + CntW'(1)) == CntW'(MaxLock)) begin
                  state_d = IDLE;
                  rr_d    = next_idx(owner_q);
                  cnt_d   = '0;
               end
            end else if (!req_we_i[owner_q] && !req_lock_i[owner_q]) begin
               // Owner walked away without holding the lock: release.
               state_d = IDLE;
               rr_d    = next_idx(owner_q);
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : spatz_vrf_warb

// File: tb/tb_spatz_vrf_warb.sv
// Directed bench for the VRF write arbiter.
module tb_spatz_vrf_warb;
   import spatz_pkg::*;

   logic             clk;
   logic             rst;
   vreg_addr_t [2:0] waddr;
   vreg_data_t [2:0] wdata;
   vreg_be_t   [2:0] wbe;
   logic       [2:0] we;
   logic       [2:0] lock;
   logic       [2:0] wvalid_o;
   vreg_addr_t       vaddr;
   vreg_data_t       vdata;
   vreg_be_t         vbe;
   logic             vwe;
   logic             vwvalid;

   int checks = 0;
   int errors = 0;

   spatz_vrf_warb #(.NrReq(3), .MaxLock(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_waddr_i  (waddr),
      .req_wdata_i  (wdata),
      .req_wbe_i    (wbe),
      .req_we_i     (we),
      .req_lock_i   (lock),
      .req_wvalid_o (wvalid_o),
      .vrf_waddr_o  (vaddr),
      .vrf_wdata_o  (vdata),
      .vrf_wbe_o    (vbe),
      .vrf_we_o     (vwe),
      .vrf_wvalid_i (vwvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grants must be one-hot or empty every cycle.
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(wvalid_o)) begin
         errors++;
         $display("FAIL onehot0 req_wvalid_o=%b", wvalid_o);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      we = '0; lock = '0; vwvalid = 1'b1;
      rst = 1'b1;
      cyc();
      @(negedge clk);
      checks++;
      if ({vwe, vaddr, vdata, vbe, wvalid_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got we=%b a=%h d=%h be=%h v=%b exp all 0",
                  vwe, vaddr, vdata, vbe, wvalid_o);
      end
      cyc();
      rst = 1'b0;
      checks++;
      if (dut.rr_q !== 2'd0 || dut.cnt_q !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got rr=%0d cnt=%0d exp 0 0", dut.rr_q, dut.cnt_q);
      end
   endtask

   task automatic test_round_robin();
      int exp_w[6] = '{0, 1, 2, 0, 1, 2};
      do_reset();
      we = 3'b111; lock = 3'b000; vwvalid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (wvalid_o !== (3'b001 << exp_w[i]) || vaddr !== (8'h10 + 8'(exp_w[i]))) begin
            errors++;
            $display("FAIL rr_beat%0d got v=%b a=%h exp v=%b a=%h", i, wvalid_o, vaddr,
                     3'b001 << exp_w[i], 8'h10 + 8'(exp_w[i]));
         end
         cyc();
      end
      we = '0;
   endtask

   task automatic test_lock_burst();
      int exp_w[6] = '{2, 2, 2, 2, 0, 2};
      do_reset();
      we = 3'b100; lock = 3'b100; vwvalid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (wvalid_o !== (3'b001 << exp_w[i]) || vdata !== (32'hA0 + 32'(exp_w[i]))) begin
            errors++;
            $display("FAIL lock_beat%0d got v=%b d=%h exp v=%b d=%h", i, wvalid_o, vdata,
                     3'b001 << exp_w[i], 32'hA0 + 32'(exp_w[i]));
         end
         cyc();
         we = 3'b101;
      end
      we = '0; lock = '0;
   endtask

   task automatic test_stall();
      do_reset();
      we = 3'b010; lock = '0; vwvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (vwe !== 1'b1 || vaddr !== 8'h11 || wvalid_o !== 3'b000 || dut.rr_q !== 2'd0) begin
            errors++;
            $display("FAIL stall%0d got we=%b a=%h v=%b rr=%0d exp 1 11 000 0",
                     i, vwe, vaddr, wvalid_o, dut.rr_q);
         end
         cyc();
      end
      vwvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b010 || vbe !== 4'h2) begin
         errors++;
         $display("FAIL stall_release got v=%b be=%h exp 010 2", wvalid_o, vbe);
      end
      cyc();
      we = '0;
   endtask

   task automatic test_bubble();
      do_reset();
      we = 3'b010; lock = 3'b010; vwvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b010) begin
         errors++;
         $display("FAIL bubble_first got v=%b exp 010", wvalid_o);
      end
      cyc();
      we = 3'b001;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (vwe !== 1'b0 || wvalid_o !== 3'b000 || vaddr !== 8'h00) begin
            errors++;
            $display("FAIL bubble%0d got we=%b v=%b a=%h exp 0 000 00", i, vwe, wvalid_o, vaddr);
         end
         cyc();
      end
      we = 3'b011;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b010 || vaddr !== 8'h11) begin
         errors++;
         $display("FAIL bubble_resume got v=%b a=%h exp 010 11", wvalid_o, vaddr);
      end
      cyc();
      we = '0; lock = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      we = 3'b100; lock = 3'b100; vwvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b100) begin
         errors++;
         $display("FAIL midrst_first got v=%b exp 100", wvalid_o);
      end
      cyc();
      we = 3'b101;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b100) begin
         errors++;
         $display("FAIL midrst_locked got v=%b exp 100", wvalid_o);
      end
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (wvalid_o !== 3'b001 || vaddr !== 8'h10) begin
         errors++;
         $display("FAIL midrst_after got v=%b a=%h exp 001 10", wvalid_o, vaddr);
      end
      cyc();
      we = '0; lock = '0;
   endtask

   task automatic test_idle();
      we = '0; lock = 3'b111; vwvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({vwe, vaddr, vdata, vbe, wvalid_o} !== '0) begin
            errors++;
            $display("FAIL idle%0d got we=%b a=%h d=%h be=%h v=%b exp all 0",
                     i, vwe, vaddr, vdata, vbe, wvalid_o);
         end
         cyc();
      end
      lock = '0;
   endtask

   initial begin
      rst = 1'b1; we = '0; lock = '0; vwvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         waddr[i] = 8'h10 + 8'(i);
         wdata[i] = 32'hA0 + 32'(i);
         wbe[i]   = 4'(1 << i);
      end
      test_reset();
      test_round_robin();
      test_lock_burst();
      test_stall();
      test_bubble();
      test_reset_mid_burst();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spatz_vrf_warb
